// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg -- shared definitions for the KGP RISC front end.
//   XLEN              : datapath / address width
//   DEFAULT_RESET_PC  : PC loaded on reset unless overridden
//   ifu_state_t       : fetch FSM states
//     FETCH : request outstanding to instruction memory
//     HOLD  : instruction held for the downstream stage
//     KILL  : draining a stale response after a redirect
package kgp_risc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ifu_perf_counter.sv
// ifu_perf_counter -- fetch-unit performance counters (built only when
// IFU_PERF_CNT_EN is defined in instruction_fetch_unit).
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears both counts)
//   count_fetch   : accepted-instruction event this cycle
//   count_stall   : valid-but-not-accepted event this cycle
//   fetch_count   : accepted instructions, wraps at 2^XLEN
//   stall_count   : stalled cycles, wraps at 2^XLEN
module ifu_perf_counter
    import kgp_risc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            count_fetch,
    input  logic            count_stall,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count
);

    logic [XLEN-1:0] fetch_count_q, fetch_count_d;
    logic [XLEN-1:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (count_fetch) fetch_count_d = fetch_count_q + 1'b1;
        if (count_stall) stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit -- single-outstanding-request instruction fetcher.
// Build option: define IFU_PERF_CNT_EN to add fetch_count / stall_count.
// Parameters:
//   RESET_PC : PC loaded on reset
//   PC_STEP  : sequential increment (word-addressed PC)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   imem_req/imem_addr  : registered fetch request and address (= pc_out)
//   imem_ack/imem_rdata : memory response, data valid with ack
//   redirect/redirect_pc: taken branch/jump target
//   instr_out/pc_out    : instruction and its PC towards decode
//   instr_valid         : instr_out/pc_out valid; accepted with instr_ready
//   fetch_count, stall_count (IFU_PERF_CNT_EN only)
module instruction_fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = kgp_risc_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count
`endif
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            req_q, req_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            FETCH: begin
                // req_q is low only in the cycle right after reset; no
                // request is outstanding then, so ack is ignored and a
                // redirect has nothing to drain.
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (req_q && !imem_ack) state_d = KILL;
                end else if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end
            KILL: begin
                // A redirect only retargets the PC; the stale ack still
                // ends the drain, otherwise the FSM would wait forever.
                if (redirect) pc_d = redirect_pc;
                if (imem_ack) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = (state_q == HOLD);

`ifdef IFU_PERF_CNT_EN
    // A redirect wins over instr_ready, so that cycle is not a handshake.
    ifu_perf_counter u_perf (
        .clk         (clk),
        .rst         (rst),
        .count_fetch (instr_valid && instr_ready && !redirect),
        .count_stall (instr_valid && !instr_ready),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit -- directed self-checking bench for
// instruction_fetch_unit (default parameters). Counter checks are compiled
// in when IFU_PERF_CNT_EN is defined.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    instruction_fetch_unit #(
        .RESET_PC (32'd0),
        .PC_STEP  (32'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        tick();
        tick();

        // Reset state
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req",   {31'd0, imem_req},    32'd0);
        check("rst_pc",    pc_out,               32'd0);
        check("rst_instr", instr_out,            32'd0);
`ifdef IFU_PERF_CNT_EN
        check("rst_fcnt", fetch_count, 32'd0);
        check("rst_scnt", stall_count, 32'd0);
`endif

        // Release reset: request rises after the first edge with rst=0
        rst = 1'b0;
        tick();
        check("rel_req",   {31'd0, imem_req},    32'd1);
        check("rel_addr",  imem_addr,            32'd0);
        check("rel_valid", {31'd0, instr_valid}, 32'd0);

        // Zero-wait ack
        imem_ack   = 1'b1;
        imem_rdata = 32'hA5A5_0001;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("ack_valid", {31'd0, instr_valid}, 32'd1);
        check("ack_instr", instr_out,            32'hA5A5_0001);
        check("ack_pc",    pc_out,               32'd0);
        check("ack_req",   {31'd0, imem_req},    32'd0);

        // Five stall cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr_out,            32'hA5A5_0001);
            check("stall_pc",    pc_out,               32'd0);
        end
`ifdef IFU_PERF_CNT_EN
        check("stall_scnt", stall_count, 32'd5);
`endif

        // Accept: sequential PC
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("seq_req",   {31'd0, imem_req},    32'd1);
        check("seq_addr",  imem_addr,            32'd1);
        check("seq_valid", {31'd0, instr_valid}, 32'd0);
`ifdef IFU_PERF_CNT_EN
        check("seq_fcnt", fetch_count, 32'd1);
`endif

        // Redirect together with ready in HOLD
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0011;
        tick();
        imem_ack   = 1'b0;
        check("h2_instr", instr_out, 32'h0000_0011);
        check("h2_pc",    pc_out,    32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        instr_ready = 1'b1;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        check("rdh_valid", {31'd0, instr_valid}, 32'd0);
        check("rdh_req",   {31'd0, imem_req},    32'd1);
        check("rdh_addr",  imem_addr,            32'h40);
`ifdef IFU_PERF_CNT_EN
        check("rdh_fcnt", fetch_count, 32'd1);
`endif

        // Redirect in FETCH without ack, stale ack three cycles later
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect    = 1'b0;
        check("kill_req",   {31'd0, imem_req},    32'd0);
        check("kill_valid", {31'd0, instr_valid}, 32'd0);
        check("kill_pc",    pc_out,               32'h80);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("killw_req",   {31'd0, imem_req},    32'd0);
            check("killw_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        check("drain_valid", {31'd0, instr_valid}, 32'd0);
        check("drain_req",   {31'd0, imem_req},    32'd1);
        check("drain_addr",  imem_addr,            32'h80);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0022;
        tick();
        imem_ack   = 1'b0;
        check("new_valid", {31'd0, instr_valid}, 32'd1);
        check("new_instr", instr_out,            32'h0000_0022);
        check("new_pc",    pc_out,               32'h80);

        // Redirect in FETCH with simultaneous ack: data dropped, stay FETCH
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("acc2_addr", imem_addr, 32'h81);
        imem_ack    = 1'b1;
        imem_rdata  = 32'h0000_0033;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        check("rda_req",   {31'd0, imem_req},    32'd1);
        check("rda_valid", {31'd0, instr_valid}, 32'd0);
        check("rda_addr",  imem_addr,            32'h100);

        // PC wrap-around at 32'hFFFF_FFFF (ack+redirect again keeps FETCH)
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect    = 1'b0;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
        imem_rdata = 32'h0000_0044;
        tick();
        imem_ack   = 1'b0;
        check("wrap_instr", instr_out, 32'h0000_0044);
        check("wrap_pc",    pc_out,    32'hFFFF_FFFF);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("wrap_addr", imem_addr,         32'h0);
        check("wrap_req",  {31'd0, imem_req}, 32'd1);
`ifdef IFU_PERF_CNT_EN
        check("wrap_fcnt", fetch_count, 32'd3);
        check("wrap_scnt", stall_count, 32'd5);
`endif

        // Redirect while in KILL retargets the PC and stays in KILL
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect    = 1'b0;
        check("k2_pc",    pc_out,               32'h300);
        check("k2_req",   {31'd0, imem_req},    32'd0);
        check("k2_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack   = 1'b0;
        check("k2_fetch_req",  {31'd0, imem_req}, 32'd1);
        check("k2_fetch_addr", imem_addr,         32'h300);

        // Reset in HOLD with redirect asserted
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0055;
        tick();
        imem_ack   = 1'b0;
        check("h5_valid", {31'd0, instr_valid}, 32'd1);
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        instr_ready = 1'b1;
        tick();
        check("rh_valid", {31'd0, instr_valid}, 32'd0);
        check("rh_pc",    pc_out,               32'd0);
        check("rh_req",   {31'd0, imem_req},    32'd0);
        check("rh_instr", instr_out,            32'd0);
`ifdef IFU_PERF_CNT_EN
        check("rh_fcnt", fetch_count, 32'd0);
        check("rh_scnt", stall_count, 32'd0);
`endif
        rst         = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        tick();
        check("rh_rel_req",  {31'd0, imem_req}, 32'd1);
        check("rh_rel_addr", imem_addr,         32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
